// File: rtl/dice_pkg.sv
// Shared types and constants for the dice result display path.
`timescale 1ns/1ps
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int DATA_W     = 8;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    // Segment codes gfedcba for digits 0..9, digit 0 in the low seven bits.
    localparam logic [69:0] SEG_FONT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [6:0]  SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_font(input logic [3:0] digit);
        logic [6:0] code;
        code = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == 4'(i)) code = SEG_FONT[i*7 +: 7];
        end
        return code;
    endfunction

endpackage

// File: rtl/dice_display_driver_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, result committed in DONE.
`timescale 1ns/1ps
module bin2bcd_seq
    import dice_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  result
);

    localparam int SH_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t           state;
    logic [SH_W-1:0]  shift;
    logic [SH_W-1:0]  adjusted;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        adjusted = shift;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (shift[DATA_W + 4*d +: 4] >= 4'd5)
                adjusted[DATA_W + 4*d +: 4] = shift[DATA_W + 4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shift  <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift <= {{BCD_W{1'b0}}, bin};
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift <= {adjusted[SH_W-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE: begin
                    result <= shift[SH_W-1:DATA_W];
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/dice_display_driver.sv
// Converts the roller result to BCD on change and drives a multiplexed
// 3-digit 7-segment display with leading-zero blanking.
`timescale 1ns/1ps
module dice_display_driver
    import dice_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value_in,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd,
    output logic              bcd_valid,
    output logic [6:0]        seg,
    output logic [2:0]        digit_en
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_RST  = SEG_ACTIVE_LOW ? ~seg_font(4'd0) : seg_font(4'd0);

    logic [DATA_W-1:0] cap;
    logic              start;
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        digit_idx;
    logic [3:0]        nibble;
    logic              blank;
    logic [6:0]        seg_raw;

    // A conversion starts only from idle; changes seen while busy are
    // picked up on return because cap still holds the older value.
    assign start = !busy && (value_in != cap);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap <= '0;
        end else if (start) begin
            cap <= value_in;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin    (value_in),
        .busy   (busy),
        .done   (bcd_valid),
        .result (bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? 2'd0 : digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        nibble = bcd[3:0];
        blank  = 1'b0;
        case (digit_idx)
            2'd1: begin
                nibble = bcd[7:4];
                blank  = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nibble = bcd[11:8];
                blank  = (bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
        seg_raw = blank ? SEG_BLANK : seg_font(nibble);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_en <= 3'b001;
            seg      <= SEG_RST;
        end else begin
            digit_en <= blank ? 3'b000 : 3'(3'b001 << digit_idx);
            seg      <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        end
    end

endmodule

// File: tb/tb_dice_display_driver.sv
// Scoreboard bench for dice_display_driver: active-high and active-low segment builds side by side.
`timescale 1ns/1ps
module tb_dice_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value_in;

    logic        busy, bcd_valid;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    logic        busy_b, valid_b;
    logic [11:0] bcd_b;
    logic [6:0]  seg_b;
    logic [2:0]  en_b;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;

    always #5 clk = ~clk;

    dice_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .reset(reset), .value_in(value_in), .busy(busy),
        .bcd(bcd), .bcd_valid(bcd_valid), .seg(seg), .digit_en(digit_en)
    );

    dice_display_driver #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(reset), .value_in(value_in), .busy(busy_b),
        .bcd(bcd_b), .bcd_valid(valid_b), .seg(seg_b), .digit_en(en_b)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every bcd_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bcd_valid) begin
            if (exp_q.size() == 0) begin
                check("bcd_valid_unexpected", {20'd0, bcd}, 32'hFFFF_FFFF);
            end else begin
                exp_v = exp_q.pop_front();
                check("bcd_valid_data", {20'd0, bcd}, {20'd0, exp_v});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observes one full 12-cycle frame and counts cycles per digit pattern.
    task automatic check_frame(input bit inv, input logic [6:0] u, input logic [6:0] t,
                               input logic [6:0] h, input bit t_blank, input bit h_blank,
                               input string tag);
        int n_u, n_t, n_h, n_b;
        logic [2:0] en;
        logic [6:0] sg, blank_code, fu, ft, fh;
        blank_code = inv ? 7'h7F : 7'h00;
        fu = inv ? ~u : u;
        ft = inv ? ~t : t;
        fh = inv ? ~h : h;
        n_u = 0; n_t = 0; n_h = 0; n_b = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            en = inv ? en_b : digit_en;
            sg = inv ? seg_b : seg;
            if (en == 3'b001 && sg == fu) n_u++;
            else if (en == 3'b010 && sg == ft) n_t++;
            else if (en == 3'b100 && sg == fh) n_h++;
            else if (en == 3'b000 && sg == blank_code) n_b++;
        end
        check({tag, "_units"}, n_u, 4);
        check({tag, "_tens"}, n_t, t_blank ? 0 : 4);
        check({tag, "_hundreds"}, n_h, h_blank ? 0 : 4);
        check({tag, "_blank"}, n_b, 4 * (int'(t_blank) + int'(h_blank)));
    endtask

    initial begin
        int busy_cnt, valid_at, first_at, second_at;

        reset = 1'b1;
        value_in = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_bcd", bcd, 0);
        check("rst_bcd_valid", bcd_valid, 0);
        check("rst_digit_en", digit_en, 3'b001);
        check("rst_seg", seg, 7'h3F);
        check("rst_seg_low", seg_b, 7'h40);
        check("rst_busy_low", busy_b, 0);
        check("rst_bcd_low", bcd_b, 0);
        check("rst_valid_low", valid_b, 0);

        tick(50);
        check("idle_bcd", bcd, 0);
        check_frame(1'b0, 7'h3F, 7'h3F, 7'h3F, 1'b1, 1'b1, "zero");

        // 0 -> 17: busy for nine cycles, result one cycle later
        value_in = 8'd17;
        exp_q.push_back(12'h017);
        busy_cnt = 0;
        valid_at = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (bcd_valid && valid_at < 0) valid_at = k;
        end
        check("busy_cycles_17", busy_cnt, 9);
        check("valid_latency_17", valid_at, 9);
        tick(2);
        check_frame(1'b0, 7'h07, 7'h06, 7'h00, 1'b0, 1'b1, "v17");
        check_frame(1'b1, 7'h07, 7'h06, 7'h00, 1'b0, 1'b1, "v17_low");

        value_in = 8'd255;
        exp_q.push_back(12'h255);
        tick(14);
        check_frame(1'b0, 7'h6D, 7'h6D, 7'h5B, 1'b0, 1'b0, "v255");

        value_in = 8'd105;
        exp_q.push_back(12'h105);
        tick(14);
        check_frame(1'b0, 7'h6D, 7'h3F, 7'h06, 1'b0, 1'b0, "v105");

        // Same number rolled again: nothing should happen
        value_in = 8'd105;
        tick(15);
        check("reroll_bcd", bcd, 12'h105);
        check("reroll_busy", busy, 0);

        // 5 then 20 while the first conversion is in flight
        value_in = 8'd5;
        exp_q.push_back(12'h005);
        exp_q.push_back(12'h020);
        first_at = -1;
        second_at = -1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bcd_valid) begin
                if (first_at < 0) first_at = k;
                else if (second_at < 0) second_at = k;
            end
            if (k == 2) value_in = 8'd20;
        end
        check("b2b_first_at", first_at, 9);
        check("b2b_second_at", second_at, 19);
        check("b2b_bcd", bcd, 12'h020);

        // Reset in the middle of a conversion
        value_in = 8'd200;
        tick(3);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_valid", bcd_valid, 0);
        tick(3);
        exp_q.push_back(12'h200);
        reset = 1'b0;
        tick(12);
        check("post_reset_bcd", bcd, 12'h200);
        check_frame(1'b0, 7'h3F, 7'h3F, 7'h5B, 1'b0, 1'b0, "v200");

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
